// File: rtl/int_ram_loader.sv
// Writer side of the intrinsic RAM pair: saturates serial channel LLRs and
// writes even samples to bank 0 and odd samples to bank 1, then holds the frame until the decoder releases it.
module int_ram_loader #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int IN_WIDTH   = 8,
    parameter int FRAME_LEN  = 512
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [IN_WIDTH-1:0]              llr_in,
    input  logic                             llr_valid,
    output logic                             llr_ready,
    output logic [1:0][ADDR_WIDTH-1:0]       ram_address,
    output logic [1:0][DATA_WIDTH-1:0]       ram_data_in,
    output logic [1:0]                       ram_we,
    output logic [1:0]                       ram_cs,
    output logic                             busy,
    output logic                             frame_done,
    input  logic                             bank_release,
    output logic [15:0]                      sat_count
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic signed [IN_WIDTH-1:0] POS_LIM = IN_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] NEG_LIM = -POS_LIM;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic signed [IN_WIDTH-1:0]  llr_s;
    logic                        over, under, clamp, accept;
    logic [DATA_WIDTH-1:0]       sat_val;

    assign llr_s  = llr_in;
    assign accept = llr_valid && llr_ready;

    // Symmetric clamp: the most negative DATA_WIDTH code is never produced.
    always_comb begin
        over    = llr_s > POS_LIM;
        under   = llr_s < NEG_LIM;
        clamp   = over || under;
        sat_val = llr_in[DATA_WIDTH-1:0];
        if (over)
            sat_val = POS_LIM[DATA_WIDTH-1:0];
        else if (under)
            sat_val = NEG_LIM[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sat_count   <= '0;
            llr_ready   <= 1'b0;
            ram_we      <= '0;
            ram_cs      <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            ram_we     <= '0;
            ram_cs     <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        sat_count <= '0;
                        llr_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ram_we[cnt[0]]      <= 1'b1;
                        ram_cs[cnt[0]]      <= 1'b1;
                        ram_address[cnt[0]] <= cnt[CW-1:1];
                        ram_data_in[cnt[0]] <= sat_val;
                        if (clamp && sat_count != 16'hFFFF)
                            sat_count <= sat_count + 16'd1;
                        // frame_done lands on the same cycle as the last write.
                        if (cnt == LAST) begin
                            state      <= HOLD;
                            llr_ready  <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bank_release) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    llr_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
